// File: rtl/nes_pad_pkg.sv
// Shared types and bit-position constants for the NES pad responder.
// NES_* index the NES serial order; MJ_* index the MiSTer joystick word.
package nes_pad_pkg;

    localparam int NES_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        SHIFT,
        DONE
    } state_t;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    localparam int MJ_RIGHT  = 0;
    localparam int MJ_LEFT   = 1;
    localparam int MJ_DOWN   = 2;
    localparam int MJ_UP     = 3;
    localparam int MJ_A      = 4;
    localparam int MJ_B      = 5;
    localparam int MJ_SELECT = 6;
    localparam int MJ_START  = 7;

    // Electrical level on the data pin for a button that is (or is not) pressed.
    function automatic logic pad_level(input logic pressed, input logic active_low);
        return pressed ^ active_low;
    endfunction

endpackage

// File: rtl/nes_edge_sync.sv
// Synchroniser for one asynchronous pad-protocol pin, followed by a history
// flop so that single-cycle rise and fall pulses can be derived.
module nes_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: answers the poller's latch / pad_clk / data protocol
// with the MiSTer joystick word remapped into NES serial order.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW_DATA = 1'b1,
    parameter bit SOCD_CLEAN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  joy_in,
    input  logic        latch,
    input  logic        pad_clk,
    output logic        data,
    output logic        busy,
    output logic [3:0]  bit_index,
    output logic        poll_strobe,
    output logic [15:0] poll_count
);

    logic latch_level, latch_rise, latch_fall;
    logic clk_level, clk_rise, clk_fall;

    nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (latch),
        .level_o (latch_level),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (pad_clk),
        .level_o (clk_level),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    // Latch entry is level-driven and pad_clk falls carry no meaning.
    logic unused_edges;
    assign unused_edges = &{1'b0, latch_rise, clk_level, clk_fall};

    logic [NES_BITS-1:0] nes_raw;
    logic [NES_BITS-1:0] nes_map;

    // NOTE: every always_comb output gets a default first, so no path can leave
    // a bit unassigned and infer a latch.
    always_comb begin
        nes_raw             = '0;
        nes_raw[NES_A]      = joy_in[MJ_A];
        nes_raw[NES_B]      = joy_in[MJ_B];
        nes_raw[NES_SELECT] = joy_in[MJ_SELECT];
        nes_raw[NES_START]  = joy_in[MJ_START];
        nes_raw[NES_UP]     = joy_in[MJ_UP];
        nes_raw[NES_DOWN]   = joy_in[MJ_DOWN];
        nes_raw[NES_LEFT]   = joy_in[MJ_LEFT];
        nes_raw[NES_RIGHT]  = joy_in[MJ_RIGHT];

        nes_map = nes_raw;
        if (SOCD_CLEAN) begin
            if (nes_raw[NES_UP] && nes_raw[NES_DOWN]) begin
                nes_map[NES_UP]   = 1'b0;
                nes_map[NES_DOWN] = 1'b0;
            end
            if (nes_raw[NES_LEFT] && nes_raw[NES_RIGHT]) begin
                nes_map[NES_LEFT]  = 1'b0;
                nes_map[NES_RIGHT] = 1'b0;
            end
        end
    end

    state_t              state_q;
    logic [NES_BITS-1:0] sr_q;
    logic                data_q;
    logic                busy_q;
    logic [3:0]          bit_index_q;
    logic                poll_strobe_q;
    logic [15:0]         poll_count_q;

    // NOTE: the shift register is an 8-bit state register, not a memory, so it is
    // reset like any other flop; the not-pressed fill keeps data inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            data_q        <= pad_level(1'b0, ACTIVE_LOW_DATA);
            busy_q        <= 1'b0;
            bit_index_q   <= '0;
            poll_strobe_q <= 1'b0;
            poll_count_q  <= '0;
        end else begin
            poll_strobe_q <= 1'b0;
            if (latch_level) begin
                // Latch wins over everything, including a same-cycle pad_clk rise.
                state_q     <= LATCHED;
                sr_q        <= nes_map;
                data_q      <= pad_level(nes_map[NES_A], ACTIVE_LOW_DATA);
                busy_q      <= 1'b1;
                bit_index_q <= '0;
            end else begin
                unique case (state_q)
                    LATCHED: begin
                        if (latch_fall) begin
                            state_q       <= SHIFT;
                            poll_strobe_q <= 1'b1;
                            poll_count_q  <= poll_count_q + 16'd1;
                        end
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            sr_q        <= {1'b0, sr_q[NES_BITS-1:1]};
                            data_q      <= pad_level(sr_q[1], ACTIVE_LOW_DATA);
                            bit_index_q <= bit_index_q + 4'd1;
                            if (bit_index_q == 4'(NES_BITS - 1)) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign data        = data_q;
    assign busy        = busy_q;
    assign bit_index   = bit_index_q;
    assign poll_strobe = poll_strobe_q;
    assign poll_count  = poll_count_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: a default instance and a raw instance
// (3 sync stages, active-high data, no SOCD cleaning) driven by the same pins.
module tb_nes_pad_responder;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  joy_in  = '0;
    logic        latch   = 1'b0;
    logic        pad_clk = 1'b0;

    logic        a_data, a_busy, a_strobe;
    logic [3:0]  a_index;
    logic [15:0] a_count;
    logic        b_data, b_busy, b_strobe;
    logic [3:0]  b_index;
    logic [15:0] b_count;

    int checks   = 0;
    int failures = 0;
    int strobes_a = 0;
    int strobes_b = 0;

    logic exp_a[$];
    logic exp_b[$];

    nes_pad_responder dut (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .latch       (latch),
        .pad_clk     (pad_clk),
        .data        (a_data),
        .busy        (a_busy),
        .bit_index   (a_index),
        .poll_strobe (a_strobe),
        .poll_count  (a_count)
    );

    nes_pad_responder #(
        .SYNC_STAGES     (3),
        .ACTIVE_LOW_DATA (1'b0),
        .SOCD_CLEAN      (1'b0)
    ) dut_raw (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .latch       (latch),
        .pad_clk     (pad_clk),
        .data        (b_data),
        .busy        (b_busy),
        .bit_index   (b_index),
        .poll_strobe (b_strobe),
        .poll_count  (b_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_strobe) strobes_a++;
        if (b_strobe) strobes_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Independent reference for the joystick -> NES remap and SOCD cleaning.
    function automatic logic [7:0] nes_model(input logic [7:0] j, input bit socd);
        logic [7:0] n;
        n = {j[0], j[1], j[2], j[3], j[7], j[6], j[5], j[4]};
        if (socd && n[4] && n[5]) n[5:4] = 2'b00;
        if (socd && n[6] && n[7]) n[7:6] = 2'b00;
        return n;
    endfunction

    task automatic push_frame(input logic [7:0] j);
        logic [7:0] na, nb;
        na = nes_model(j, 1'b1);
        nb = nes_model(j, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_a.push_back(~na[i]);
            exp_b.push_back(nb[i]);
        end
        exp_a.push_back(1'b1);
        exp_b.push_back(1'b0);
    endtask

    task automatic pop_check(input string tag);
        logic ea, eb;
        if (exp_a.size() == 0) ea = 1'bx;
        else ea = exp_a.pop_front();
        if (exp_b.size() == 0) eb = 1'bx;
        else eb = exp_b.pop_front();
        check({tag, "_a"}, {31'd0, a_data}, {31'd0, ea});
        check({tag, "_b"}, {31'd0, b_data}, {31'd0, eb});
    endtask

    task automatic flush_sb();
        exp_a.delete();
        exp_b.delete();
    endtask

    // Latch with j_early, switch to j_late while latched, drop latch, check bit 0.
    task automatic latch_frame(input logic [7:0] j_early, input logic [7:0] j_late, input string tag);
        joy_in = j_early;
        latch  = 1'b1;
        cycles(6);
        joy_in = j_late;
        cycles(6);
        check({tag, "_busy_latched"}, {31'd0, a_busy}, 32'd1);
        latch = 1'b0;
        push_frame(j_late);
        cycles(6);
        pop_check({tag, "_bit0"});
    endtask

    task automatic shift_checked(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            pad_clk = 1'b1;
            cycles(6);
            pop_check(tag);
            pad_clk = 1'b0;
            cycles(6);
        end
    endtask

    task automatic pad_pulse();
        pad_clk = 1'b1;
        cycles(6);
        pad_clk = 1'b0;
        cycles(6);
    endtask

    initial begin
        int base_a, base_b;

        // Reset and idle
        cycles(3);
        check("rst_data_a", {31'd0, a_data}, 32'd1);
        check("rst_data_b", {31'd0, b_data}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_count", {16'd0, a_count}, 32'd0);
        check("rst_index", {28'd0, a_index}, 32'd0);
        reset = 1'b0;
        cycles(4);
        pad_pulse();
        pad_pulse();
        check("idle_index_a", {28'd0, a_index}, 32'd0);
        check("idle_index_b", {28'd0, b_index}, 32'd0);
        check("idle_data_a", {31'd0, a_data}, 32'd1);
        check("idle_busy", {31'd0, a_busy}, 32'd0);
        check("idle_count", {16'd0, a_count}, 32'd0);

        // A + Right with exact latch-fall latency on both instances
        joy_in = 8'b0001_0001;
        latch  = 1'b1;
        cycles(6);
        check("latched_busy", {31'd0, a_busy}, 32'd1);
        check("latched_index", {28'd0, a_index}, 32'd0);
        check("latched_data_a", {31'd0, a_data}, 32'd0);
        latch = 1'b0;
        push_frame(joy_in);
        cycles(2);
        check("strobe_early_a", {31'd0, a_strobe}, 32'd0);
        cycles(1);
        check("strobe_on_a", {31'd0, a_strobe}, 32'd1);
        check("strobe_early_b", {31'd0, b_strobe}, 32'd0);
        cycles(1);
        check("strobe_off_a", {31'd0, a_strobe}, 32'd0);
        check("strobe_on_b", {31'd0, b_strobe}, 32'd1);
        cycles(2);
        pop_check("ar_bit0");
        shift_checked(8, "ar_shift");
        check("ar_done_index_a", {28'd0, a_index}, 32'd8);
        check("ar_done_index_b", {28'd0, b_index}, 32'd8);
        check("ar_done_busy", {31'd0, a_busy}, 32'd0);
        check("ar_count", {16'd0, a_count}, 32'd1);
        pad_pulse();
        check("done_ignore_index", {28'd0, a_index}, 32'd8);
        check("done_ignore_data", {31'd0, a_data}, 32'd1);

        // Up + Down: cleaned on the default instance, raw on the other
        latch_frame(8'b0000_1100, 8'b0000_1100, "socd");
        shift_checked(8, "socd_shift");

        // joy_in changes while latched and while shifting
        latch_frame(8'b0001_0000, 8'b1110_0010, "chg");
        shift_checked(3, "chg_shift");
        joy_in = 8'hFF;
        shift_checked(5, "chg_shift_late");
        check("chg_count", {16'd0, a_count}, 32'd3);

        // Re-latch after 3 clocks, with a pad_clk rise on the same synced cycle
        latch_frame(8'b0001_0101, 8'b0001_0101, "rl");
        shift_checked(3, "rl_shift");
        latch   = 1'b1;
        pad_clk = 1'b1;
        flush_sb();
        cycles(6);
        check("relatch_index_a", {28'd0, a_index}, 32'd0);
        check("relatch_index_b", {28'd0, b_index}, 32'd0);
        check("relatch_data_a", {31'd0, a_data}, 32'd0);
        check("relatch_data_b", {31'd0, b_data}, 32'd1);
        check("relatch_busy", {31'd0, a_busy}, 32'd1);
        pad_clk = 1'b0;
        cycles(6);
        pad_pulse();
        check("latched_clk_index", {28'd0, a_index}, 32'd0);
        latch_frame(8'b0001_0101, 8'b0001_0101, "rl2");
        shift_checked(8, "rl2_shift");
        check("rl_count", {16'd0, a_count}, 32'd5);

        // Reset in the middle of a frame
        latch_frame(8'b0001_0001, 8'b0001_0001, "rst");
        shift_checked(4, "rst_shift");
        reset = 1'b1;
        #1;
        check("midrst_data_a", {31'd0, a_data}, 32'd1);
        check("midrst_data_b", {31'd0, b_data}, 32'd0);
        check("midrst_busy", {31'd0, a_busy}, 32'd0);
        check("midrst_index", {28'd0, a_index}, 32'd0);
        check("midrst_count", {16'd0, a_count}, 32'd0);
        flush_sb();
        @(negedge clk);
        reset = 1'b0;
        cycles(3);
        pad_pulse();
        check("postrst_index", {28'd0, a_index}, 32'd0);
        check("postrst_data_a", {31'd0, a_data}, 32'd1);
        check("postrst_busy", {31'd0, a_busy}, 32'd0);

        // poll_count wrap: 65535 pulses reach 0xFFFF, one more wraps to 0
        base_a = strobes_a;
        base_b = strobes_b;
        for (int i = 0; i < 65535; i++) begin
            latch = 1'b1;
            @(negedge clk);
            latch = 1'b0;
            @(negedge clk);
        end
        cycles(6);
        check("wrap_ffff_a", {16'd0, a_count}, 32'h0000_FFFF);
        check("wrap_ffff_b", {16'd0, b_count}, 32'h0000_FFFF);
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
        cycles(6);
        check("wrap_zero_a", {16'd0, a_count}, 32'd0);
        check("wrap_zero_b", {16'd0, b_count}, 32'd0);
        check("wrap_strobes_a", 32'(strobes_a - base_a), 32'd65536);
        check("wrap_strobes_b", 32'(strobes_b - base_b), 32'd65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Emulates a standard NES controller: the responder end of the latch / clock / serial-data pad protocol driven by the game logic's pad poller.
- Takes the MiSTer joystick word from hps_io, remaps it to NES bit order, and cleans opposing directions.
- Serialises one button per pad clock back to the poller's data input.
- Sits in emu between hps_io joystick_0 and display_top latch/nes_clk/data.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on latch and pad_clk inputs; legal range 1..3.
- ACTIVE_LOW_DATA, 1: 1 means pressed = 0 on data, matching real pad; 0 means pressed = 1.
- SOCD_CLEAN, 1: 1 clears both bits of Up+Down or Left+Right when both are pressed simultaneously.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  asynchronous, active-high reset.
- joy_in  in  8  MiSTer joystick, active-high: [0]Right [1]Left [2]Down [3]Up [4]A [5]B [6]Select [7]Start.
- latch  in  1  pad latch from poller; high means parallel load.
- pad_clk  in  1  pad shift clock from poller; shift happens on its rising edge.
- data  out  1  serial button data to poller.
- busy  out  1  high in LATCHED or SHIFT.
- bit_index  out  4  number of bits shifted since the latch fell, 0..8.
- poll_strobe  out  1  one-cycle pulse on each latch falling edge.
- poll_count  out  16  count of latch falling edges; wraps 0xFFFF to 0.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE
  - shift register all not-pressed
  - data = inactive level (1 if ACTIVE_LOW_DATA, else 0)
  - busy = 0, bit_index = 0, poll_strobe = 0, poll_count = 0
  - sync flops and edge-history flops = 0
- Input conditioning:
  - latch and pad_clk each pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Rise = sync & ~hist; fall = ~sync & hist.
- Remap to NES order, nes[7:0]:
  - nes[0]=A(joy4), nes[1]=B(joy5), nes[2]=Select(joy6), nes[3]=Start(joy7)
  - nes[4]=Up(joy3), nes[5]=Down(joy2), nes[6]=Left(joy1), nes[7]=Right(joy0)
  - SOCD_CLEAN applied after remap.
  - joy_in is sampled only when the shift register loads.
- Shift register: 8 bits, stored active-high internally. data is a registered copy of sr[0], inverted when ACTIVE_LOW_DATA is 1.
- States:
  - IDLE: not polled since reset; data inactive. Latch-sync high -> LATCHED.
  - LATCHED: shift register reloads from the remapped joy_in every cycle; data follows A; bit_index = 0. Latch fall -> SHIFT, pulse poll_strobe, poll_count +1.
  - SHIFT: on each pad_clk rise, sr shifts right with 0 (not-pressed) filled at bit 7, and bit_index +1. The rise that makes bit_index = 8 -> DONE.
  - DONE: data inactive (shift-in fill exhausted); further pad_clk rises ignored; bit_index holds 8.
- Latch-sync high in any state -> LATCHED. This has priority over a same-cycle pad_clk rise, and that clock rise is discarded.
- pad_clk rises in IDLE or LATCHED are ignored. pad_clk rises while latch is high never shift.
- busy = (state == LATCHED) | (state == SHIFT).
- Latency: a latch or pad_clk pin edge updates data, bit_index and poll_strobe SYNC_STAGES+1 cycles later. The poller must keep pad_clk half-periods ≥ SYNC_STAGES+2 cycles.
- Latch falling and rising edges are never simultaneous (single wire), so no extra priority rule is needed.
- Reset mid-shift: returns to IDLE with data inactive; no partial frame is resumed.

Decomposition:
- Package nes_pad_pkg holds:
  - typedef state_t {IDLE, LATCHED, SHIFT, DONE}
  - localparam index constants NES_A..NES_RIGHT (0..7) and MJ_RIGHT..MJ_START (0..7)
  - localparam NES_BITS = 8
- One sub-module, nes_edge_sync: parameterised SYNC_STAGES synchroniser plus rise/fall detector, instantiated twice (latch, pad_clk).
- Remap and SOCD stay combinational in the top.

Test Plan:
- Reset then idle: data = 1, busy = 0, poll_count = 0 with no stimulus; pad_clk pulses alone leave bit_index = 0.
- joy_in = 8'b0001_0001 (A + Right), latch pulse, 8 pad_clk pulses:
  - Required: data after fall = 0 (A), then the bit sequence 1,1,1,1,1,1,0.
  - After the 8th clock: data = 1, bit_index = 8, state DONE, poll_count = 1.
- joy_in Up+Down = 8'b0000_1100 with SOCD_CLEAN = 1 -> all 8 serial bits = 1. With SOCD_CLEAN = 0 -> bits 4 and 5 = 0.
- Change joy_in during LATCHED: the last value before the latch fall is the one serialised. Change joy_in during SHIFT: the serial stream is unaffected.
- Latch re-asserted after 3 clocks: bit_index returns to 0, data shows A again, and a pad_clk rise in the same synced cycle does not shift.
- Reset asserted after 4 clocks -> immediate IDLE, data = 1. Separately, force 65536 latch pulses -> poll_count wraps to 0, with poll_strobe pulsing once per pulse.
